// File: rtl/mem_bus_pkg.sv
// Shared memory-bus constants and elaboration-time helpers.
package mem_bus_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_SW = 4;

  // Read data handed back to a master whose transfer the watchdog aborted.
  localparam logic [MEM_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Index width that never collapses to zero bits for a single master.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_if.sv
// Master-side and slave-side signals of the shared memory arbiter.
// slave  : the arbiter's view (it serves the N requesters).
// master : the surrounding system (requesters plus the memory responder).
interface mem_arb_rr_if #(
  parameter int unsigned N_MASTERS = 4
) ();
  import mem_bus_pkg::*;

  localparam int unsigned IdW = idx_width(N_MASTERS);

  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS-1:0]        m_ready;
  logic [MEM_AW*N_MASTERS-1:0] m_addr;
  logic [MEM_DW*N_MASTERS-1:0] m_wdata;
  logic [MEM_SW*N_MASTERS-1:0] m_wstrb;
  logic [MEM_DW-1:0]           m_rdata;

  logic                        mem_valid;
  logic                        mem_ready;
  logic [MEM_AW-1:0]           mem_addr;
  logic [MEM_DW-1:0]           mem_wdata;
  logic [MEM_SW-1:0]           mem_wstrb;
  logic [MEM_DW-1:0]           mem_rdata;

  logic [IdW-1:0]              grant_id;
  logic                        timeout_err;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
    output m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_id, timeout_err
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
    input  m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_id, timeout_err
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
// 'last' itself gets the lowest priority.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] last,
  output logic           any,
  output logic [IdW-1:0] idx
);

  // Scan last+1, last+2, ... modulo N and keep the first hit.
  always_comb begin
    int unsigned j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(last) + 1 + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IdW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// N-master round-robin arbiter in front of one memory slave, with a
// watchdog that aborts hung transfers with an error response.
module mem_arb_rr
  import mem_bus_pkg::*;
#(
  parameter int unsigned       N_MASTERS = 4,
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [MEM_DW-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  mem_arb_rr_if.slave bus
);

  localparam int unsigned IdW = idx_width(N_MASTERS);
  localparam int unsigned WdW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [WdW-1:0] WdLast = (TIMEOUT > 0) ? WdW'(TIMEOUT - 1) : '0;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [IdW-1:0] last_q, last_d;
  logic [WdW-1:0] wd_q, wd_d;

  logic           busy, timeout, done;
  logic [IdW-1:0] pick_last, pick_idx;
  logic           pick_any;

  // While busy the owner is about to become 'last', so rotate from it directly;
  // this is what makes back-to-back grants bubble-free.
  always_comb begin
    busy      = (state_q == StBusy);
    timeout   = (TIMEOUT > 0) && busy && !bus.mem_ready && (wd_q == WdLast);
    done      = busy && (bus.mem_ready || timeout);
    pick_last = busy ? owner_q : last_q;
  end

  rr_pick #(
    .N(N_MASTERS)
  ) u_pick (
    .req (bus.m_valid),
    .last(pick_last),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state: grant from idle, rotate or release on completion, run watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          owner_d = pick_idx;
          wd_d    = '0;
        end
      end
      StBusy: begin
        if (done) begin
          last_d = owner_q;
          wd_d   = '0;
          if (pick_any) owner_d = pick_idx;
          else          state_d = StIdle;
        end else if (TIMEOUT > 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last resets to N-1 so master 0 wins the first grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdW'(N_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Owner-indexed muxes and completion strobe; mem_ready beats the watchdog.
  always_comb begin
    bus.mem_valid = busy;
    bus.mem_addr  = bus.m_addr[MEM_AW*owner_q +: MEM_AW];
    bus.mem_wdata = bus.m_wdata[MEM_DW*owner_q +: MEM_DW];
    bus.mem_wstrb = bus.m_wstrb[MEM_SW*owner_q +: MEM_SW];
    bus.m_ready   = '0;
    if (done) bus.m_ready[owner_q] = 1'b1;
    bus.m_rdata     = timeout ? ERR_RDATA : bus.mem_rdata;
    bus.grant_id    = busy ? owner_q : '0;
    bus.timeout_err = timeout;
  end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr: vector table plus watchdog and reset sequences.
module tb_mem_arb_rr;
  import mem_bus_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arb_rr_if #(.N_MASTERS(N)) bus ();

  mem_arb_rr #(
    .N_MASTERS(N),
    .TIMEOUT  (8),
    .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] mv;
    logic       mr;
    logic       exp_memv;
    logic [3:0] exp_rdy;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [31:0] addr_of(input int unsigned i);
    return 32'hA000_0000 + (i << 8);
  endfunction

  function automatic logic [31:0] wdata_of(input int unsigned i);
    return 32'hB000_0000 + i;
  endfunction

  function automatic logic [3:0] wstrb_of(input int unsigned i);
    return 4'(i + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Drive one cycle's inputs on the falling edge, settle, then let checks run.
  task automatic drive(input logic r, input logic [3:0] mv, input logic mr,
                       input logic [31:0] rd);
    @(negedge clk);
    rst           = r;
    bus.m_valid   = mv;
    bus.mem_ready = mr;
    bus.mem_rdata = rd;
    #1;
  endtask

  task automatic check_bus(input string tag, input logic exp_memv, input logic [3:0] exp_rdy,
                           input logic [1:0] gid, input logic terr, input logic [31:0] exp_rd);
    check({tag, " mem_valid"}, 32'(bus.mem_valid), 32'(exp_memv));
    check({tag, " m_ready"}, 32'(bus.m_ready), 32'(exp_rdy));
    check({tag, " grant_id"}, 32'(bus.grant_id), 32'(gid));
    check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(terr));
    if (exp_memv) begin
      check({tag, " mem_addr"}, bus.mem_addr, addr_of(gid));
      check({tag, " mem_wdata"}, bus.mem_wdata, wdata_of(gid));
      check({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(wstrb_of(gid)));
    end
    if (exp_rdy != 4'b0000) check({tag, " m_rdata"}, bus.m_rdata, exp_rd);
  endtask

  initial begin
    for (int unsigned i = 0; i < N; i++) begin
      bus.m_addr[32*i +: 32]  = addr_of(i);
      bus.m_wdata[32*i +: 32] = wdata_of(i);
      bus.m_wstrb[4*i +: 4]   = wstrb_of(i);
    end
    bus.m_valid   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    //            rst   mv       mr    memv  rdy      gid
    // Single request: reset state, 1-cycle latency, one m_ready pulse, back to idle.
    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[2]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};
    // All request, slave always ready: 0,1,2,3,0 with no bubbles.
    vecs[5]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    // Master 1 completes with only 0 and 3 left: 3 outranks 0.
    vecs[12] = '{1'b0, 4'b1001, 1'b1, 1'b1, 4'b0010, 2'd1};
    vecs[13] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b0000, 2'd3};
    vecs[14] = '{1'b0, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};

    drive(1'b1, 4'b0000, 1'b0, '0);
    drive(1'b1, 4'b0000, 1'b0, '0);

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].rst, vecs[k].mv, vecs[k].mr, 32'hC0DE_0000 + 32'(k));
      if (!vecs[k].rst)
        check_bus($sformatf("vec%0d", k), vecs[k].exp_memv, vecs[k].exp_rdy, vecs[k].exp_gid,
                  1'b0, 32'hC0DE_0000 + 32'(k));
    end

    // Watchdog abort of master 0 on its 8th busy cycle, then master 2 granted.
    drive(1'b1, 4'b0000, 1'b0, '0);
    drive(1'b0, 4'b0101, 1'b0, 32'h1111_1111);
    check_bus("wd idle", 1'b0, 4'b0000, 2'd0, 1'b0, '0);
    for (int n = 1; n <= 7; n++) begin
      drive(1'b0, 4'b0101, 1'b0, 32'h1111_1111);
      check_bus($sformatf("wd m0 c%0d", n), 1'b1, 4'b0000, 2'd0, 1'b0, '0);
    end
    drive(1'b0, 4'b0101, 1'b0, 32'h1111_1111);
    check_bus("wd m0 abort", 1'b1, 4'b0001, 2'd0, 1'b1, 32'hDEADBEEF);

    // Master 2: mem_ready lands exactly on the 8th cycle, so no error.
    for (int n = 1; n <= 7; n++) begin
      drive(1'b0, 4'b0100, 1'b0, 32'h2222_2222);
      check_bus($sformatf("wd m2 c%0d", n), 1'b1, 4'b0000, 2'd2, 1'b0, '0);
    end
    drive(1'b0, 4'b0000, 1'b1, 32'h1234_5678);
    check_bus("wd m2 tie", 1'b1, 4'b0100, 2'd2, 1'b0, 32'h1234_5678);
    drive(1'b0, 4'b0000, 1'b0, '0);
    check_bus("wd after", 1'b0, 4'b0000, 2'd0, 1'b0, '0);

    // Reset while master 2 is busy: withdraw, then lowest requester wins.
    drive(1'b1, 4'b0000, 1'b0, '0);
    drive(1'b0, 4'b0100, 1'b0, '0);
    check_bus("rst idle", 1'b0, 4'b0000, 2'd0, 1'b0, '0);
    drive(1'b0, 4'b0100, 1'b0, '0);
    check_bus("rst m2 busy", 1'b1, 4'b0000, 2'd2, 1'b0, '0);
    drive(1'b1, 4'b0101, 1'b1, 32'h3333_3333);
    drive(1'b0, 4'b0101, 1'b1, 32'h3333_3333);
    check_bus("rst after", 1'b0, 4'b0000, 2'd0, 1'b0, '0);
    drive(1'b0, 4'b0101, 1'b0, 32'h3333_3333);
    check_bus("rst regrant", 1'b1, 4'b0000, 2'd0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
